// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel divider, h/v counters, sync decode
// and a one-tick output stage that blanks colour and keeps it aligned with the syncs.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int COLOR_BITS = 3,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*COLOR_BITS-1:0] rgb_in,
    output logic [X_W-1:0]          x,
    output logic [Y_W-1:0]          y,
    output logic                    active,
    output logic                    pix_tick,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    hsync,
    output logic                    vsync,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]        div;
    logic [X_W-1:0]          hcnt;
    logic [Y_W-1:0]          vcnt;
    logic [3*COLOR_BITS-1:0] rgb_q;
    logic                    in_hs;
    logic                    in_vs;

    // With CLK_DIV=1 the divider never leaves 0, so the tick is permanently high.
    assign pix_tick = (div == DIV_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_tick) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + Y_W'(1);
            end else begin
                hcnt <= hcnt + X_W'(1);
            end
        end
    end

    assign x           = hcnt;
    assign y           = vcnt;
    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign line_start  = pix_tick && (hcnt == '0);
    assign frame_start = line_start && (vcnt == '0);
    assign in_hs       = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign in_vs       = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

    // Output stage advances with the pixel, so syncs and colour lag x/y by one tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~HSYNC_POL;
            vsync <= ~VSYNC_POL;
            rgb_q <= '0;
        end else if (pix_tick) begin
            hsync <= in_hs ? HSYNC_POL : ~HSYNC_POL;
            vsync <= in_vs ? VSYNC_POL : ~VSYNC_POL;
            rgb_q <= active ? rgb_in : '0;
        end
    end

    assign red   = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
    assign green = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign blue  = rgb_q[COLOR_BITS-1:0];

endmodule
